// File: rtl/ita_package.sv
// rtl/ita_package.sv - shared ITA types plus step-sequencer types and helpers
package ita_package;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int H                = 4;
  localparam int TILE_W           = 8;
  localparam int N_REQUANT_CONSTS = 6;

  typedef logic [TILE_W-1:0]                      tile_t;
  typedef logic [idx_width(H)-1:0]                n_heads_t;
  typedef logic [idx_width(N_REQUANT_CONSTS)-1:0] requant_idx_t;

  typedef enum logic [1:0] {
    LayerAttention,
    LayerFeedforward,
    LayerLinear
  } layer_e;

  typedef enum logic [3:0] {
    StepIdle,
    StepQ,
    StepK,
    StepV,
    StepQK,
    StepAV,
    StepOW,
    StepF1,
    StepF2,
    StepMatMul
  } step_e;

  typedef struct packed {
    logic   start;
    layer_e layer;
    tile_t  tile_s;
    tile_t  tile_e;
    tile_t  tile_p;
    tile_t  tile_f;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_e;

  typedef struct packed {
    step_e        step;
    n_heads_t     head;
    tile_t        outer;
    tile_t        mid;
    tile_t        inner;
    logic         first_inner;
    logic         last_inner;
    requant_idx_t requant_idx;
  } tile_desc_t;

  typedef struct packed {
    tile_t outer;
    tile_t mid;
    tile_t inner;
  } loop_lim_t;

  // A configured tile count of zero still means one tile.
  function automatic tile_t count_or_one(input tile_t n);
    return (n == '0) ? tile_t'(1) : n;
  endfunction

  function automatic requant_idx_t step_requant_idx(input step_e step);
    case (step)
      StepK:   return requant_idx_t'(1);
      StepV:   return requant_idx_t'(2);
      StepQK:  return requant_idx_t'(3);
      StepAV:  return requant_idx_t'(4);
      StepOW:  return requant_idx_t'(5);
      StepF2:  return requant_idx_t'(1);
      default: return requant_idx_t'(0);
    endcase
  endfunction

  // (outer, mid, inner) loop bounds of each step; inner is the reduction loop.
  function automatic loop_lim_t step_limits(input step_e step, input tile_t s, input tile_t e,
                                            input tile_t p, input tile_t f);
    case (step)
      StepQ, StepK, StepV: return '{outer: s, mid: p, inner: e};
      StepQK:              return '{outer: s, mid: s, inner: p};
      StepAV:              return '{outer: s, mid: p, inner: s};
      StepOW:              return '{outer: s, mid: e, inner: p};
      StepF2:              return '{outer: s, mid: e, inner: f};
      default:             return '{outer: s, mid: f, inner: e};
    endcase
  endfunction

endpackage

// File: rtl/ita_tile_loop_counter.sv
// rtl/ita_tile_loop_counter.sv - three-level nested tile coordinate counter
module ita_tile_loop_counter
  import ita_package::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      load_i,
  input  loop_lim_t lim_i,
  input  logic      advance_i,
  output tile_t     outer_o,
  output tile_t     mid_o,
  output tile_t     inner_o,
  output logic      first_inner_o,
  output logic      last_inner_o,
  output logic      last_tile_o
);

  loop_lim_t lim_q;
  tile_t     outer_q, mid_q, inner_q;
  logic      last_inner, last_mid, last_outer;

  assign last_inner = (inner_q == lim_q.inner - tile_t'(1));
  assign last_mid   = (mid_q == lim_q.mid - tile_t'(1));
  assign last_outer = (outer_q == lim_q.outer - tile_t'(1));

  assign outer_o       = outer_q;
  assign mid_o         = mid_q;
  assign inner_o       = inner_q;
  assign first_inner_o = (inner_q == '0);
  assign last_inner_o  = last_inner;
  assign last_tile_o   = last_inner && last_mid && last_outer;

  // Load restarts at (0,0,0) with new bounds; advance steps inner fastest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lim_q   <= '0;
      outer_q <= '0;
      mid_q   <= '0;
      inner_q <= '0;
    end else if (load_i) begin
      lim_q   <= lim_i;
      outer_q <= '0;
      mid_q   <= '0;
      inner_q <= '0;
    end else if (advance_i) begin
      if (!last_inner) begin
        inner_q <= inner_q + tile_t'(1);
      end else begin
        inner_q <= '0;
        if (!last_mid) begin
          mid_q <= mid_q + tile_t'(1);
        end else begin
          mid_q   <= '0;
          outer_q <= last_outer ? '0 : outer_q + tile_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ita_step_sequencer.sv
// rtl/ita_step_sequencer.sv - layer step scheduler with tile handshake and drain tracking; optional ITA_SEQ_PERF_COUNTERS_EN
module ita_step_sequencer
  import ita_package::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned NHeads         = ita_package::H
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  ctrl_t        ctrl_i,
  output logic         tile_valid_o,
  input  logic         tile_ready_i,
  output step_e        step_o,
  output n_heads_t     head_o,
  output tile_t        outer_o,
  output tile_t        mid_o,
  output tile_t        inner_o,
  output logic         first_inner_o,
  output logic         last_inner_o,
  output requant_idx_t requant_idx_o,
  input  logic         tile_done_i,
  output logic         busy_o,
  output logic         done_o
`ifdef ITA_SEQ_PERF_COUNTERS_EN
  ,
  output tile_t        perf_cycles_o,
  output tile_t        perf_stall_o
`endif
);

  localparam int unsigned OutW = idx_width(int'(MaxOutstanding + 1));
  localparam logic [OutW-1:0] MaxOut   = OutW'(MaxOutstanding);
  localparam n_heads_t        LastHead = n_heads_t'(NHeads - 1);

  seq_state_e      state_q, state_d;
  layer_e          layer_q;
  tile_t           s_q, e_q, p_q, f_q;
  step_e           step_q, nxt_step, first_step, load_step;
  n_heads_t        head_q, nxt_head, load_head;
  logic [OutW-1:0] out_q;
  logic            has_next, load, accept, hs, done_ok;
  loop_lim_t       load_lim;
  tile_desc_t      desc;

  tile_t cnt_outer, cnt_mid, cnt_inner;
  logic  cnt_first, cnt_last, cnt_last_tile;

  assign accept       = (state_q == IDLE) && ctrl_i.start;
  assign tile_valid_o = (state_q == ISSUE) && (out_q != MaxOut);
  assign hs           = tile_valid_o && tile_ready_i;
  assign done_ok      = tile_done_i && (out_q != '0);

  // Successor of the current step within the latched layer's sequence.
  always_comb begin
    nxt_step = StepIdle;
    nxt_head = head_q;
    has_next = 1'b0;
    case (step_q)
      StepQ:  begin nxt_step = StepK;  has_next = 1'b1; end
      StepK:  begin nxt_step = StepV;  has_next = 1'b1; end
      StepV:  begin nxt_step = StepQK; has_next = 1'b1; end
      StepQK: begin nxt_step = StepAV; has_next = 1'b1; end
      StepAV: begin
        has_next = 1'b1;
        if (head_q == LastHead) begin
          nxt_step = StepOW;
          nxt_head = '0;
        end else begin
          nxt_step = StepQ;
          nxt_head = head_q + n_heads_t'(1);
        end
      end
      StepF1: begin nxt_step = StepF2; has_next = 1'b1; end
      default: ;
    endcase
  end

  // The first step is loaded straight from ctrl_i since nothing is latched yet.
  always_comb begin
    first_step = StepMatMul;
    case (ctrl_i.layer)
      LayerAttention:   first_step = StepQ;
      LayerFeedforward: first_step = StepF1;
      default:          first_step = StepMatMul;
    endcase
    if (state_q == IDLE) begin
      load_step = first_step;
      load_head = '0;
      load_lim  = step_limits(first_step, count_or_one(ctrl_i.tile_s), count_or_one(ctrl_i.tile_e),
                              count_or_one(ctrl_i.tile_p), count_or_one(ctrl_i.tile_f));
    end else begin
      load_step = nxt_step;
      load_head = nxt_head;
      load_lim  = step_limits(nxt_step, s_q, e_q, p_q, f_q);
    end
  end

  // FSM next state; a step is loaded only once the previous one has fully drained.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_i.start) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (hs && cnt_last_tile) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_q == '0) begin
          if (has_next) begin
            state_d = ISSUE;
            load    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Layer and tile counts are captured once per run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      layer_q <= LayerAttention;
      s_q     <= '0;
      e_q     <= '0;
      p_q     <= '0;
      f_q     <= '0;
    end else if (accept) begin
      layer_q <= ctrl_i.layer;
      s_q     <= count_or_one(ctrl_i.tile_s);
      e_q     <= count_or_one(ctrl_i.tile_e);
      p_q     <= count_or_one(ctrl_i.tile_p);
      f_q     <= count_or_one(ctrl_i.tile_f);
    end
  end

  // Current step and head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_q <= StepIdle;
      head_q <= '0;
    end else if (load) begin
      step_q <= load_step;
      head_q <= load_head;
    end
  end

  // Outstanding tiles: issued and not yet reported complete.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      case ({hs, done_ok})
        2'b10:   out_q <= out_q + OutW'(1);
        2'b01:   out_q <= out_q - OutW'(1);
        default: out_q <= out_q;
      endcase
    end
  end

  ita_tile_loop_counter u_loop (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_i        (load),
    .lim_i         (load_lim),
    .advance_i     (hs),
    .outer_o       (cnt_outer),
    .mid_o         (cnt_mid),
    .inner_o       (cnt_inner),
    .first_inner_o (cnt_first),
    .last_inner_o  (cnt_last),
    .last_tile_o   (cnt_last_tile)
  );

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  always_comb begin
    desc = '0;
    desc.step = StepIdle;
    if (busy_o) begin
      desc.step        = step_q;
      desc.head        = head_q;
      desc.outer       = cnt_outer;
      desc.mid         = cnt_mid;
      desc.inner       = cnt_inner;
      desc.first_inner = cnt_first;
      desc.last_inner  = cnt_last;
      desc.requant_idx = step_requant_idx(step_q);
    end
  end

  assign step_o        = desc.step;
  assign head_o        = desc.head;
  assign outer_o       = desc.outer;
  assign mid_o         = desc.mid;
  assign inner_o       = desc.inner;
  assign first_inner_o = desc.first_inner;
  assign last_inner_o  = desc.last_inner;
  assign requant_idx_o = desc.requant_idx;

`ifndef SYNTHESIS
  // A completion with nothing outstanding means the datapath and sequencer disagree.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(tile_done_i && (out_q == '0)));
`endif

`ifdef ITA_SEQ_PERF_COUNTERS_EN
  tile_t perf_cycles_q, perf_stall_q;

  // Saturating busy and stall cycle counters, cleared when a run is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (accept) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_o && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + tile_t'(1);
      if (tile_valid_o && !tile_ready_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + tile_t'(1);
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_ita_step_sequencer.sv
// tb/tb_ita_step_sequencer.sv - randomized self-checking bench for ita_step_sequencer
module tb_ita_step_sequencer;
  import ita_package::*;

  localparam int MAX_OUT = 2;
  localparam int N_H     = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  ctrl_t        ctrl = '0;
  logic         tile_valid, tile_ready = 1'b0, tile_done = 1'b0;
  step_e        step;
  n_heads_t     head;
  tile_t        outer, mid, inner;
  logic         first_inner, last_inner, busy, done;
  requant_idx_t rq_idx;
`ifdef ITA_SEQ_PERF_COUNTERS_EN
  tile_t        perf_cycles, perf_stall;
`endif

  always #5 clk = ~clk;

  ita_step_sequencer #(.MaxOutstanding(MAX_OUT), .NHeads(N_H)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ctrl_i        (ctrl),
    .tile_valid_o  (tile_valid),
    .tile_ready_i  (tile_ready),
    .step_o        (step),
    .head_o        (head),
    .outer_o       (outer),
    .mid_o         (mid),
    .inner_o       (inner),
    .first_inner_o (first_inner),
    .last_inner_o  (last_inner),
    .requant_idx_o (rq_idx),
    .tile_done_i   (tile_done),
    .busy_o        (busy),
    .done_o        (done)
`ifdef ITA_SEQ_PERF_COUNTERS_EN
    ,
    .perf_cycles_o (perf_cycles),
    .perf_stall_o  (perf_stall)
`endif
  );

  typedef struct {
    step_e step;
    int    head, outer, mid, inner, rq;
    bit    first, last;
  } exp_t;

  exp_t  exp_q[$];
  int    done_due[$];
  int    n_checks = 0, n_pass = 0;
  int    cyc = 0, model_out = 0, last_due = 0, zero_at = 0, start_cyc = 0;
  int    job_hs = 0, done_pulses = 0, release_cnt = 0, bp_left = 0;
  int    busy_model = 0, stall_model = 0;
  bit    hold_done = 0, ready_rand = 0, rand_dly = 0, bp_arm = 0, start_req = 0, prev_stall = 0;
  logic [31:0] prev_desc = '0;
  step_e prev_valid_step = StepIdle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] obs_word();
    return {4'(step), 4'(head), outer, mid, inner};
  endfunction

  function automatic void add_step(step_e st, int h, int no, int nm, int ni, int rq);
    for (int o = 0; o < no; o++)
      for (int m = 0; m < nm; m++)
        for (int i = 0; i < ni; i++) begin
          exp_t x;
          x.step = st; x.head = h; x.outer = o; x.mid = m; x.inner = i; x.rq = rq;
          x.first = (i == 0); x.last = (i == ni - 1);
          exp_q.push_back(x);
        end
  endfunction

  function automatic void build(layer_e l, int s, int e, int p, int f);
    s = (s == 0) ? 1 : s; e = (e == 0) ? 1 : e;
    p = (p == 0) ? 1 : p; f = (f == 0) ? 1 : f;
    exp_q.delete();
    if (l == LayerAttention) begin
      for (int h = 0; h < N_H; h++) begin
        add_step(StepQ,  h, s, p, e, 0);
        add_step(StepK,  h, s, p, e, 1);
        add_step(StepV,  h, s, p, e, 2);
        add_step(StepQK, h, s, s, p, 3);
        add_step(StepAV, h, s, p, s, 4);
      end
      add_step(StepOW, 0, s, e, p, 5);
    end else if (l == LayerFeedforward) begin
      add_step(StepF1, 0, s, f, e, 0);
      add_step(StepF2, 0, s, e, f, 1);
    end else begin
      add_step(StepMatMul, 0, s, f, e, 0);
    end
  endfunction

  task automatic run_cycle();
    logic [31:0] cur, expw;
    bit hs, dn;
    int due;
    @(posedge clk); #1; cyc++;
    cur = obs_word();
    if (prev_stall) begin
      check("valid_held", tile_valid, 1'b1);
      check("desc_held", cur, prev_desc);
    end
    if (model_out == MAX_OUT) check("credit_block", tile_valid, 1'b0);
    if (tile_valid && step != prev_valid_step) begin
      check("step_start_cycle", cyc, (prev_valid_step == StepIdle) ? start_cyc + 1 : zero_at + 1);
      check("drained_before_step", model_out, 0);
      prev_valid_step = step;
    end
    if (done) done_pulses++;
    if (busy) busy_model++;
    // inputs for this cycle
    ctrl.start = start_req;
    if (start_req) start_cyc = cyc;
    else if (busy) begin
      ctrl.layer  = layer_e'($urandom_range(0, 2));
      ctrl.tile_s = 8'($urandom); ctrl.tile_e = 8'($urandom);
      ctrl.tile_p = 8'($urandom); ctrl.tile_f = 8'($urandom);
    end
    start_req = 0;
    if (bp_arm && job_hs >= 2 && tile_valid) begin bp_arm = 0; bp_left = 5; end
    if (bp_left > 0) begin tile_ready = 1'b0; bp_left--; end
    else tile_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    dn = 0;
    if (done_due.size() > 0 && done_due[0] <= cyc && (!hold_done || release_cnt > 0)) begin
      void'(done_due.pop_front());
      dn = 1;
      if (hold_done) release_cnt--;
    end
    tile_done = dn;
    hs = tile_valid && tile_ready;
    if (hs) begin
      if (exp_q.size() > 0) begin
        exp_t x = exp_q.pop_front();
        expw = {4'(x.step), 4'(x.head), 8'(x.outer), 8'(x.mid), 8'(x.inner)};
        check("desc_flags", {27'b0, first_inner, last_inner, rq_idx}, 32'({x.first, x.last, 3'(x.rq)}));
      end else begin
        expw = 32'hFFFF_FFFF;
      end
      check("desc_coord", cur, expw);
      job_hs++;
      due = cyc + (rand_dly ? int'($urandom_range(1, 6)) : 2);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      done_due.push_back(due);
    end
    if (tile_valid && !tile_ready) stall_model++;
    prev_stall = tile_valid && !tile_ready;
    prev_desc  = cur;
    model_out  = model_out + int'(hs) - int'(dn);
    if (dn && model_out == 0) zero_at = cyc + 1;
  endtask

  task automatic start_job(layer_e l, int s, int e, int p, int f);
    build(l, s, e, p, f);
    ctrl.layer = l;
    ctrl.tile_s = 8'(s); ctrl.tile_e = 8'(e); ctrl.tile_p = 8'(p); ctrl.tile_f = 8'(f);
    prev_valid_step = StepIdle;
    done_pulses = 0; job_hs = 0; busy_model = 0; stall_model = 0;
    start_req = 1;
    run_cycle();
  endtask

  task automatic finish_job(int mid_start_at);
    bit got = 0;
    int done_cyc = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      if (i == mid_start_at) start_req = 1;
      run_cycle();
      if (done) begin got = 1; done_cyc = cyc; end
    end
    check("job_done_seen", got, 1'b1);
    check("done_timing", done_cyc, zero_at + 1);
    check("all_desc_issued", exp_q.size(), 0);
    run_cycle();
    check("busy_drops", busy, 1'b0);
    check("done_single_pulse", done_pulses, 1);
`ifdef ITA_SEQ_PERF_COUNTERS_EN
    check("perf_cycles", perf_cycles, (busy_model > 255) ? 255 : busy_model);
    check("perf_stall", perf_stall, (stall_model > 255) ? 255 : stall_model);
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl_outs", {19'b0, busy, tile_valid, done, 4'(step), 2'(head), first_inner, last_inner, rq_idx},
          {19'b0, 3'b000, 4'(StepIdle), 2'b00, 2'b00, 3'b000});
    check("rst_coords", {8'b0, outer, mid, inner}, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
`ifdef ITA_SEQ_PERF_COUNTERS_EN
    check("rst_perf", {16'b0, perf_cycles, perf_stall}, 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Linear s=2 f=1 e=3, ready high, done two cycles after each handshake
    start_job(LayerLinear, 2, 3, 1, 1);
    finish_job(-1);

    // Attention with unit tiles
    start_job(LayerAttention, 1, 1, 1, 1);
    finish_job(-1);

    // Credit limit: done withheld
    hold_done = 1; release_cnt = 0;
    start_job(LayerLinear, 4, 1, 1, 1);
    repeat (10) run_cycle();
    check("credit_hs", job_hs, 2);
    check("credit_valid_low", tile_valid, 1'b0);
    release_cnt = 1;
    repeat (10) run_cycle();
    check("credit_one_more", job_hs, 3);
    hold_done = 0;
    finish_job(-1);

    // Backpressure mid-step
    bp_arm = 1;
    start_job(LayerLinear, 2, 4, 1, 1);
    finish_job(-1);
`ifdef ITA_SEQ_PERF_COUNTERS_EN
    check("perf_stall_bp", perf_stall, 5);
`endif

    // Feedforward with tile_f = 0 and a start pulse while busy
    start_job(LayerFeedforward, 2, 2, 1, 0);
    finish_job(5);

    // Reset while draining
    hold_done = 1; release_cnt = 0;
    start_job(LayerAttention, 1, 1, 1, 1);
    for (int i = 0; i < 20 && job_hs < 1; i++) run_cycle();
    repeat (3) run_cycle();
    check("pre_rst_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    tile_done = 1'b0; tile_ready = 1'b0; ctrl.start = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete(); done_due.delete();
    model_out = 0; last_due = 0; hold_done = 0; prev_stall = 0;
    @(negedge clk) rst_n = 1'b1;
    start_job(LayerAttention, 2, 1, 2, 1);
    finish_job(-1);

    // Randomized runs
    ready_rand = 1; rand_dly = 1;
    for (int j = 0; j < 8; j++) begin
      start_job(layer_e'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      finish_job($urandom_range(2, 12));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
